// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: decodes LDUR/STUR, runs the req/ack/rvalid handshake
// and stalls the pipeline until the access retires. Optional timeout: MEMCTRL_TIMEOUT_EN.
module dmem_access_ctrl #(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata_q,
    output logic              stall,
    output logic              wb_en,
    output logic              busy,
    output logic              err
);

    // Handshake: mem_req/mem_we come straight from the registered REQ state and hold
    // until the cycle mem_ack is seen; mem_rvalid counts only in REQ (after ack) or WAIT.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;

    state_t state, state_nxt;
    logic   is_load, is_mem;
    logic   is_load_q, aborted_q;
    logic   capture, abort, timeout, start;
    logic   unused_bits;

    assign is_load     = (instr[31:21] == OP_LDUR);
    assign is_mem      = is_load || (instr[31:21] == OP_STUR);
    assign start       = (state == IDLE) && (state_nxt == REQ);
    assign unused_bits = ^{instr[20:0], TIMEOUT_CYCLES != 0};

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: if (instr_valid && is_mem) state_nxt = REQ;
            REQ: begin
                if (mem_ack && (!is_load_q || mem_rvalid)) begin
                    capture   = is_load_q;
                    state_nxt = DONE;
                end else if (timeout) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end else if (mem_ack) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (timeout) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            is_load_q <= 1'b0;
            aborted_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                is_load_q <= is_load;
                aborted_q <= 1'b0;
            end
            if (abort)   aborted_q <= 1'b1;
            if (capture) rdata_q   <= mem_rdata;
        end
    end

`ifdef MEMCTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // Counter value is the number of REQ/WAIT cycles already spent before this one.
    assign timeout = ((state == REQ) || (state == WAIT)) &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start)
                tmo_cnt <= '0;
            else if ((state == REQ) || (state == WAIT))
                tmo_cnt <= tmo_cnt + 1'b1;
            if (abort) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    assign mem_req = (state == REQ);
    assign mem_we  = mem_req && !is_load_q;
    assign stall   = ((state == IDLE) && instr_valid && is_mem) ||
                     (state == REQ) || (state == WAIT);
    assign wb_en   = (state == DONE) && is_load_q && !aborted_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: per-cycle vector table plus hand-written timeout sequence.
module tb_dmem_access_ctrl;

    localparam int DATA_W = 64;
    localparam logic [31:0] LD  = 32'hF840_0000;
    localparam logic [31:0] ST  = 32'hF800_0000;
    localparam logic [31:0] CBZ = 32'hB400_0000;
    localparam logic [31:0] ADD = 32'h8B00_0000;
    localparam logic [63:0] D1  = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D2  = 64'h11223344_55667788;
    localparam logic [63:0] D3  = 64'hFFFF0000_FFFF0000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              mem_req, mem_we, mem_ack, mem_rvalid;
    logic [DATA_W-1:0] mem_rdata, rdata_q;
    logic              stall, wb_en, busy, err;

    dmem_access_ctrl #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rdata_q(rdata_q),
        .stall(stall), .wb_en(wb_en), .busy(busy), .err(err)
    );

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        iv, ack, rv;
        logic [63:0] rdata;
        logic        e_req, e_we, e_stall, e_wb, e_busy;
        logic [63:0] e_rdq;
    } vec_t;

    vec_t              vq[$];
    logic [DATA_W-1:0] exp_q[$];
    int                checks   = 0;
    int                failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst_n, input logic [31:0] ins, input logic iv,
                       input logic ack, input logic rv, input logic [63:0] rd,
                       input logic e_req, input logic e_we, input logic e_stall,
                       input logic e_wb, input logic e_busy, input logic [63:0] e_rdq);
        vec_t v;
        v.rst_n = rst_n; v.instr = ins; v.iv = iv; v.ack = ack; v.rv = rv; v.rdata = rd;
        v.e_req = e_req; v.e_we = e_we; v.e_stall = e_stall; v.e_wb = e_wb;
        v.e_busy = e_busy; v.e_rdq = e_rdq;
        vq.push_back(v);
    endtask

    // driver: inputs change just after posedge, outputs checked at negedge
    task automatic apply(input vec_t v, input int idx);
        reset = v.rst_n; instr = v.instr; instr_valid = v.iv;
        mem_ack = v.ack; mem_rvalid = v.rv; mem_rdata = v.rdata;
        if (v.e_wb) exp_q.push_back(v.e_rdq);
        @(negedge clk);
        chk($sformatf("v%0d_mem_req", idx), 64'(mem_req), 64'(v.e_req));
        chk($sformatf("v%0d_mem_we", idx),  64'(mem_we),  64'(v.e_we));
        chk($sformatf("v%0d_stall", idx),   64'(stall),   64'(v.e_stall));
        chk($sformatf("v%0d_wb_en", idx),   64'(wb_en),   64'(v.e_wb));
        chk($sformatf("v%0d_busy", idx),    64'(busy),    64'(v.e_busy));
        chk($sformatf("v%0d_rdata_q", idx), rdata_q,      v.e_rdq);
        chk($sformatf("v%0d_err", idx),     64'(err),     64'd0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every wb_en pulse must commit the next expected load value
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected: got wb_en=1 expected no pending load at %0t", $time);
            end else begin
                chk("wb_data", rdata_q, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_cycles, stall_cycles;
        bit done_seen;

        reset = 1'b0; instr = '0; instr_valid = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_wb_en",   64'(wb_en),   64'd0);
        chk("rst_busy",    64'(busy),    64'd0);
        chk("rst_stall",   64'(stall),   64'd0);
        chk("rst_rdata_q", rdata_q,      64'd0);
        chk("rst_err",     64'(err),     64'd0);

        // STUR, ack on 2nd REQ cycle
        add(1, ST, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        add(1, ST, 1, 0, 0, 0,  1, 1, 1, 0, 1, 0);
        add(1, ST, 1, 1, 0, 0,  1, 1, 1, 0, 1, 0);
        add(1, ST, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // LDUR, ack+rvalid in first REQ cycle
        add(1, LD, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0);
        add(1, LD, 1, 1, 1, D1, 1, 0, 1, 0, 1, 0);
        add(1, LD, 1, 0, 0, 0,  0, 0, 0, 1, 1, D1);
        add(1, 0,  0, 0, 1, D3, 0, 0, 0, 0, 0, D1);
        // LDUR, rvalid three WAIT cycles after ack (stray ack in WAIT)
        add(1, LD, 1, 0, 0, 0,  0, 0, 1, 0, 0, D1);
        add(1, LD, 1, 1, 0, 0,  1, 0, 1, 0, 1, D1);
        add(1, LD, 1, 1, 0, 0,  0, 0, 1, 0, 1, D1);
        add(1, LD, 1, 0, 0, 0,  0, 0, 1, 0, 1, D1);
        add(1, LD, 1, 0, 1, D2, 0, 0, 1, 0, 1, D1);
        add(1, LD, 1, 0, 0, 0,  0, 0, 0, 1, 1, D2);
        add(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, D2);
        // non-memory instructions and an invalid STUR
        add(1, CBZ, 1, 1, 0, 0,  0, 0, 0, 0, 0, D2);
        add(1, ADD, 1, 0, 1, D3, 0, 0, 0, 0, 0, D2);
        add(1, ST,  0, 0, 0, 0,  0, 0, 0, 0, 0, D2);
        add(1, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0, D2);
        // reset while in WAIT; late rvalid ignored
        add(1, LD, 1, 0, 0, 0,  0, 0, 1, 0, 0, D2);
        add(1, LD, 1, 1, 0, 0,  1, 0, 1, 0, 1, D2);
        add(0, LD, 1, 0, 0, 0,  0, 0, 1, 0, 1, D2);
        add(1, 0,  0, 0, 1, D3, 0, 0, 0, 0, 0, 0);
        add(1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // LDUR that is never acknowledged
        reset = 1'b1; instr = LD; instr_valid = 1'b1;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = D3;
        req_cycles = 0; stall_cycles = 0; done_seen = 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (busy && !stall) begin
                done_seen = 1'b1;
                chk("tmo_wb_en", 64'(wb_en), 64'd0);
                chk("tmo_err_at_done", 64'(err), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        chk("tmo_done_seen", 64'(done_seen), 64'd1);
        chk("tmo_req_cycles", 64'(req_cycles), 64'd16);
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_err_sticky", 64'(err), 64'd1);
        chk("tmo_idle_busy", 64'(busy), 64'd0);
        chk("tmo_rdata_q", rdata_q, 64'd0);
`else
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            @(posedge clk);
            #1;
        end
        chk("hang_stall_cycles", 64'(stall_cycles), 64'd120);
        chk("hang_mem_req", 64'(mem_req), 64'd1);
        chk("hang_err", 64'(err), 64'd0);
`endif
        reset = 1'b0; instr_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst2_err", 64'(err), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_stall", 64'(stall), 64'd0);
        chk("rst2_mem_req", 64'(mem_req), 64'd0);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
